sid_audio_out: RTL and testbench

- Downstream consumer of the SID's 16-bit mixed voice sample, which the SID updates once per 1 MHz phase-1 period.
- Decimates that sample stream by 2^DECIM_LOG2 using a boxcar accumulate-and-dump, then holds the result in a one-entry buffer.
- Serialises the held sample as a standard I2S stereo frame, with the mono sample sent on both channels, for the board audio codec.
- Sits between sid and the top-level audio pins; the I2S bit clock is generated from the system clock.

---
 rtl/sid_audio_pkg.sv | 11 +
 rtl/sid_audio_decim.sv | 51 +++++
 rtl/sid_audio_out.sv | 91 +++++++++
 tb/tb_sid_audio_out.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sid_audio_pkg.sv
// Shared constants for the SID audio output path: I2S frame geometry and
// decimator accumulator sizing.
package sid_audio_pkg;
    localparam int SAMPLE_BITS = 16;
    localparam int SLOT_BITS   = 32;
    localparam int FRAME_BITS  = 64;

    function automatic int acc_width(input int decim_log2);
        return SAMPLE_BITS + decim_log2;
    endfunction
endpackage

// File: rtl/sid_audio_decim.sv
// Boxcar accumulate-and-dump decimator for the SID sample stream.
module sid_audio_decim
    import sid_audio_pkg::*;
#(
    parameter int DECIM_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ph1_en,
    input  logic [SAMPLE_BITS-1:0] wave,
    input  logic                   busy,
    output logic                   dump,
    output logic [SAMPLE_BITS-1:0] sample,
    output logic                   sample_valid,
    output logic                   overrun
);
    localparam int AW = acc_width(DECIM_LOG2);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic [DECIM_LOG2-1:0] cnt;

    assign sum  = acc + {{DECIM_LOG2{wave[SAMPLE_BITS-1]}}, wave};
    assign dump = ph1_en && (cnt == '1);

    // Taking the top SAMPLE_BITS of the sum is the floor-rounded >>> DECIM_LOG2.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc          <= '0;
            cnt          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            if (ph1_en) begin
                if (dump) begin
                    acc          <= '0;
                    cnt          <= '0;
                    sample       <= sum[AW-1 -: SAMPLE_BITS];
                    sample_valid <= 1'b1;
                    overrun      <= busy;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/sid_audio_out.sv
// SID audio output: decimates the mixed voice sample and serialises it as a
// mono-on-both-channels I2S frame with a locally divided bit clock.
module sid_audio_out
    import sid_audio_pkg::*;
#(
    parameter int DECIM_LOG2    = 4,
    parameter int BCLK_HALF_DIV = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_1mhz_ph1_en,
    input  logic [SAMPLE_BITS-1:0] i_wave,
    output logic [SAMPLE_BITS-1:0] o_sample,
    output logic                   o_sample_valid,
    output logic                   o_overrun,
    output logic                   o_underrun,
    output logic                   o_i2s_bclk,
    output logic                   o_i2s_lrclk,
    output logic                   o_i2s_sd
);
    localparam int DW = (BCLK_HALF_DIV > 2) ? $clog2(BCLK_HALF_DIV) : 1;
    localparam int BW = $clog2(FRAME_BITS);
    localparam int PW = $clog2(SLOT_BITS);

    logic [DW-1:0]          div;
    logic [BW-1:0]          bidx;
    logic [BW-1:0]          b_nxt;
    logic [PW-1:0]          p;
    logic [PW-1:0]          sel;
    logic [SAMPLE_BITS-1:0] word;
    logic                   pending;
    logic                   dump;
    logic                   fall;
    logic                   load;

    assign fall  = (div == DW'(BCLK_HALF_DIV - 1)) && o_i2s_bclk;
    assign b_nxt = bidx + 1'b1;
    assign load  = fall && (bidx == '1);
    assign p     = b_nxt[PW-1:0];
    assign sel   = PW'(SAMPLE_BITS) - p;

    // A load in the same cycle as a dump consumes the old sample, so the
    // dump does not count as an overwrite.
    sid_audio_decim #(.DECIM_LOG2(DECIM_LOG2)) u_decim (
        .clk          (clk),
        .rst          (rst),
        .ph1_en       (clk_1mhz_ph1_en),
        .wave         (i_wave),
        .busy         (pending && !load),
        .dump         (dump),
        .sample       (o_sample),
        .sample_valid (o_sample_valid),
        .overrun      (o_overrun)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div         <= '0;
            bidx        <= '1;
            word        <= '0;
            pending     <= 1'b0;
            o_underrun  <= 1'b0;
            o_i2s_bclk  <= 1'b0;
            o_i2s_lrclk <= 1'b1;
            o_i2s_sd    <= 1'b0;
        end else begin
            if (div == DW'(BCLK_HALF_DIV - 1)) begin
                div        <= '0;
                o_i2s_bclk <= ~o_i2s_bclk;
            end else begin
                div <= div + 1'b1;
            end

            // Slot bit p carries word bit 16-p: one-BCLK MSB delay, zero padded.
            if (fall) begin
                bidx        <= b_nxt;
                o_i2s_lrclk <= b_nxt[BW-1];
                o_i2s_sd    <= (p >= PW'(1) && p <= PW'(SAMPLE_BITS)) ? word[sel[3:0]] : 1'b0;
            end

            if (load && pending)
                word <= o_sample;
            o_underrun <= load && !pending;

            if (dump)
                pending <= 1'b1;
            else if (load)
                pending <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sid_audio_out.sv
// Bench for sid_audio_out: decimation vectors checked via a scoreboard, and
// I2S frames captured on BCLK rising edges and compared against a frame model.
module tb_sid_audio_out;
    logic        clk = 1'b0;
    logic        rst;
    logic        ph1;
    logic [15:0] wave;
    logic [15:0] o_sample;
    logic        o_sample_valid, o_overrun, o_underrun;
    logic        o_i2s_bclk, o_i2s_lrclk, o_i2s_sd;

    sid_audio_out #(.DECIM_LOG2(4), .BCLK_HALF_DIV(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_1mhz_ph1_en (ph1),
        .i_wave          (wave),
        .o_sample        (o_sample),
        .o_sample_valid  (o_sample_valid),
        .o_overrun       (o_overrun),
        .o_underrun      (o_underrun),
        .o_i2s_bclk      (o_i2s_bclk),
        .o_i2s_lrclk     (o_i2s_lrclk),
        .o_i2s_sd        (o_i2s_sd)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_ovr = 0;
    int          n_und = 0;
    logic [15:0] sbq[$];
    logic [15:0] cur_exp = 16'h0;
    logic [15:0] prev_exp = 16'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Scoreboard: every o_sample_valid pops the next expected decimated value.
    always @(negedge clk) begin
        if (o_underrun) n_und++;
        if (o_overrun)  n_ovr++;
        if (o_sample_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", {48'h0, o_sample}, 64'hx);
            end else begin
                logic [15:0] e;
                e = sbq.pop_front();
                chk("sample", {48'h0, o_sample}, {48'h0, e});
                prev_exp = cur_exp;
                cur_exp  = e;
            end
        end
    end

    function automatic logic [63:0] frame_sd(input logic [15:0] w);
        logic [63:0] f;
        for (int k = 0; k < 64; k++) begin
            int q;
            q = k % 32;
            f[k] = (q >= 1 && q <= 16) ? w[16-q] : 1'b0;
        end
        return f;
    endfunction

    typedef struct {
        logic [15:0] first;
        int          nfirst;
        logic [15:0] rest;
        logic [15:0] exp;
    } vec_t;

    task automatic feed(input logic [15:0] first, input int nfirst, input logic [15:0] rest,
                        input logic [15:0] exp);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ph1  = 1'b1;
            wave = (i < nfirst) ? first : rest;
            if (i == 15) sbq.push_back(exp);
            @(negedge clk);
            ph1 = 1'b0;
            if (i < 15) chk("valid_early", {63'h0, o_sample_valid}, 64'h0);
        end
        chk("valid_after_16th", {63'h0, o_sample_valid}, 64'h1);
        @(negedge clk);
        chk("valid_one_cycle", {63'h0, o_sample_valid}, 64'h0);
    endtask

    task automatic capture(output logic [63:0] sd_bits, output logic [63:0] lr_bits,
                           output int per, output logic und, output logic [15:0] exp_w,
                           output bit ok);
        logic pl, pb;
        int   k, last_rise;
        ok = 1'b0; sd_bits = '0; lr_bits = '0; per = 0; und = 1'b0; exp_w = '0;
        pl = o_i2s_lrclk;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (pl && !o_i2s_lrclk) begin
                ok = 1'b1;
                break;
            end
            pl = o_i2s_lrclk;
        end
        if (!ok) return;
        und = o_underrun;
        #1;
        // A dump on the load edge means the frame took the pre-dump sample.
        exp_w = o_sample_valid ? prev_exp : cur_exp;
        pb = o_i2s_bclk;
        k = 0;
        last_rise = 0;
        for (int t = 0; t < 3000 && k < 64; t++) begin
            @(negedge clk);
            if (!pb && o_i2s_bclk) begin
                sd_bits[k] = o_i2s_sd;
                lr_bits[k] = o_i2s_lrclk;
                if (k == 1) per = t - last_rise;
                last_rise = t;
                k++;
            end
            pb = o_i2s_bclk;
        end
        ok = (k == 64);
    endtask

    task automatic frame_test(input string nm, input logic und_exp, input bit use_model,
                              input logic [15:0] w);
        logic [63:0] sdb, lrb;
        int          per;
        logic        und;
        logic [15:0] ew;
        bit          ok;
        capture(sdb, lrb, per, und, ew, ok);
        chk({nm, "_found"}, {63'h0, ok}, 64'h1);
        if (ok) begin
            if (!use_model) ew = w;
            chk({nm, "_underrun"}, {63'h0, und}, {63'h0, und_exp});
            chk({nm, "_lrclk"}, lrb, 64'hFFFF_FFFF_0000_0000);
            chk({nm, "_sd"}, sdb, frame_sd(ew));
            chk({nm, "_bclk_period"}, per, 4);
        end
    endtask

    task automatic stream(input int nblk);
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                ph1  = 1'b1;
                wave = 16'h1000 + 16'(b * 16'h0111);
                if (i == 15) sbq.push_back(wave);
            end
        end
        @(negedge clk);
        ph1 = 1'b0;
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{16'h1234, 16, 16'h0000, 16'h1234};
        tbl[1] = '{16'hFF00, 16, 16'h0000, 16'hFF00};
        tbl[2] = '{16'h0010,  8, 16'h0000, 16'h0008};
        tbl[3] = '{16'hFFFF,  1, 16'h0000, 16'hFFFF};
        tbl[4] = '{16'h8000, 16, 16'h0000, 16'h8000};
        tbl[5] = '{16'h7FFF,  1, 16'h0000, 16'h07FF};
        tbl[6] = '{16'h0001, 15, 16'h0002, 16'h0001};
        tbl[7] = '{16'hFFF1,  1, 16'h0000, 16'hFFFF};

        rst = 1'b1; ph1 = 1'b0; wave = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_sample", {48'h0, o_sample}, 64'h0);
        chk("rst_valid", {63'h0, o_sample_valid}, 64'h0);
        chk("rst_overrun", {63'h0, o_overrun}, 64'h0);
        chk("rst_underrun", {63'h0, o_underrun}, 64'h0);
        chk("rst_bclk", {63'h0, o_i2s_bclk}, 64'h0);
        chk("rst_lrclk", {63'h0, o_i2s_lrclk}, 64'h1);
        chk("rst_sd", {63'h0, o_i2s_sd}, 64'h0);
        rst = 1'b0;

        foreach (tbl[i]) feed(tbl[i].first, tbl[i].nfirst, tbl[i].rest, tbl[i].exp);

        feed(16'hA5C3, 16, 16'h0000, 16'hA5C3);
        frame_test("frame_a5c3", 1'b0, 1'b0, 16'hA5C3);
        frame_test("repeat1", 1'b1, 1'b0, 16'hA5C3);
        frame_test("repeat2", 1'b1, 1'b0, 16'hA5C3);

        fork
            stream(60);
            begin
                repeat (40) @(negedge clk);
                #1;
                n_ovr = 0;
                n_und = 0;
                frame_test("fast_frame", 1'b0, 1'b1, 16'h0);
            end
        join
        repeat (2) @(negedge clk);
        chk("fast_overrun_seen", {63'h0, n_ovr > 0}, 64'h1);
        chk("fast_no_underrun", n_und, 0);
        chk("scoreboard_drained", sbq.size(), 0);

        begin
            logic [63:0] sdb, lrb;
            int          per;
            logic        und;
            logic [15:0] ew;
            bit          ok;
            capture(sdb, lrb, per, und, ew, ok);
            chk("pre_reset_frame_found", {63'h0, ok}, 64'h1);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cur_exp  = 16'h0;
        prev_exp = 16'h0;
        chk("midrst_bclk", {63'h0, o_i2s_bclk}, 64'h0);
        chk("midrst_lrclk", {63'h0, o_i2s_lrclk}, 64'h1);
        chk("midrst_sd", {63'h0, o_i2s_sd}, 64'h0);
        chk("midrst_sample", {48'h0, o_sample}, 64'h0);
        frame_test("post_reset", 1'b1, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
